// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg
//   Shared definitions for the debug UART receiver: receiver state encoding,
//   frame constants and the elaboration-time bit-timing helpers.
//   No ports (package).

package debug_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Fixed 8,n,1 frame.
  localparam int unsigned DATA_BITS   = 8;
  // Below this the three-point majority window no longer fits sensibly in a bit.
  localparam int unsigned MIN_BIT_CYC = 16;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return (clk_freq + (baud / 2)) / baud;
  endfunction

  // Mid-bit sample position.
  function automatic int unsigned half_cycles(input int unsigned bit_cyc);
    return bit_cyc / 2;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/debug_uart_rx_sync.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit.
//   Ports:
//     clk_i  - destination clock
//     rst_ni - asynchronous active-low reset (flops load RESET_VAL)
//     d_i    - asynchronous input
//     q_o    - synchronized output

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/debug_uart_rx.sv
// debug_uart_rx
//   8,n,1 UART receiver with 3-point majority sampling, framing-error
//   detection and break handling.
//   Ports:
//     clk       - single clock
//     rstn      - asynchronous active-low reset
//     uart_rx   - asynchronous serial line, idle high
//     rx_data   - last good byte (LSB = first data bit), held between bytes
//     rx_valid  - one-cycle pulse, rx_data carries a new good byte
//     frame_err - one-cycle pulse, stop bit sampled low, byte dropped
//     busy      - high whenever the receiver is not idle

module debug_uart_rx
  import debug_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 60000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned HALF    = half_cycles(BIT_CYC);
  localparam int unsigned CW      = $clog2(BIT_CYC);
  localparam int unsigned BW      = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] SMP_A    = CW'(HALF - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(HALF);
  localparam logic [CW-1:0] SMP_C    = CW'(HALF + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  if (BIT_CYC < MIN_BIT_CYC) begin : g_bad_baud
    $error("debug_uart_rx: BIT_CYC=%0d below minimum %0d", BIT_CYC, MIN_BIT_CYC);
  end

  logic                 line;
  logic                 line_prev_q;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_nxt;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic [7:0]           rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 maj;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rstn),
    .d_i    (uart_rx),
    .q_o    (line)
  );

  assign cnt_nxt = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;

  // Third sample is taken live at SMP_C so the decision is made on that edge.
  assign maj = majority3(smp_q[0], smp_q[1], line);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;

    if (state_q inside {ST_START, ST_DATA, ST_STOP}) begin
      if (cnt_q == SMP_A) smp_d[0] = line;
      if (cnt_q == SMP_B) smp_d[1] = line;
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (line_prev_q && !line) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        cnt_d = cnt_nxt;
        if ((cnt_q == SMP_C) && maj) begin
          // Start bit did not hold low at mid-bit: treat as a glitch.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        cnt_d = cnt_nxt;
        if (cnt_q == SMP_C) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end

      ST_STOP: begin
        cnt_d = cnt_nxt;
        // Leave at mid stop bit so a start edge right after the stop bit is seen.
        if (cnt_q == SMP_C) begin
          cnt_d = '0;
          if (maj) begin
            state_d = ST_IDLE;
            ok_d    = 1'b1;
          end else begin
            state_d = ST_BREAK;
            err_d   = 1'b1;
          end
        end
      end

      ST_BREAK: begin
        // Counts consecutive high cycles; any low restarts the count.
        if (!line) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_nxt;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      line_prev_q <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      smp_q       <= '0;
      shift_q     <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_prev_q <= line;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      smp_q       <= smp_d;
      shift_q     <= shift_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  // Output stage: data and valid move together; a framing error never touches data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= ok_q;
      frame_err_q <= err_q;
      if (ok_q) begin
        rx_data_q <= shift_q;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_uart_rx.sv
// tb_debug_uart_rx
//   Self-checking bench for debug_uart_rx at default parameters. A serial
//   sender drives frames cycle-accurately; a monitor logs every rx_valid byte
//   and frame_err pulse, and each scenario compares the log against the bytes
//   it expects from the frames it sent.

module tb_debug_uart_rx;

  localparam int unsigned CLK_FREQ = 60000000;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned BIT      = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned HALF     = BIT / 2;

  logic       clk;
  logic       rstn;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int unsigned cyc = 0;
  logic [7:0]  obs_data[$];
  int unsigned obs_cyc[$];
  int unsigned err_seen  = 0;
  int unsigned both_cnt  = 0;
  int unsigned wide_cnt  = 0;
  int unsigned data_bad  = 0;
  logic        valid_prev = 1'b0;
  logic        ferr_prev  = 1'b0;
  logic        rstn_prev  = 1'b0;
  logic [7:0]  data_prev  = 8'h00;
  logic [7:0]  last_good  = 8'h00;

  debug_uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && rstn_prev) begin
      if (rx_valid) begin
        obs_data.push_back(rx_data);
        obs_cyc.push_back(cyc);
      end
      if (frame_err) err_seen <= err_seen + 1;
      if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
      if ((rx_valid && valid_prev) || (frame_err && ferr_prev)) wide_cnt <= wide_cnt + 1;
      if (!rx_valid && (rx_data !== data_prev)) data_bad <= data_bad + 1;
    end
    valid_prev <= rx_valid;
    ferr_prev  <= frame_err;
    rstn_prev  <= rstn;
    data_prev  <= rx_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int unsigned len);
    uart_rx = v;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned len);
    drive_bit(1'b0, len);
    for (int i = 0; i < 8; i++) drive_bit(b[i], len);
    drive_bit(stop, len);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    uart_rx = 1'b1;
    wait_cyc(5);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %0h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    rstn = 1'b1;
    wait_cyc(1);
    checks++; if ((rx_valid | frame_err | busy) !== 1'b0) begin errors++; $display("FAIL reset_release: got valid=%0b err=%0b busy=%0b expected all 0", rx_valid, frame_err, busy); end
    wait_cyc(20);
    last_good = 8'h00;
  endtask

  task automatic test_single();
    int ob;
    int unsigned eb, t0, exp_cyc, got_cyc;
    ob = obs_data.size();
    eb = err_seen;
    t0 = cyc;
    send_frame(8'h55, 1'b1, BIT);
    wait_cyc(20);
    checks++; if (obs_data.size() - ob != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", obs_data.size() - ob); end
    if (obs_data.size() > ob) begin
      checks++; if (obs_data[ob] !== 8'h55) begin errors++; $display("FAIL single_data: got %0h expected 55", obs_data[ob]); end
      // Synchronizer + edge detect, nine bit periods, middle of the stop bit, output stages.
      exp_cyc = t0 + 3 + 9 * BIT + HALF + 3;
      got_cyc = obs_cyc[ob];
      checks++; if ((got_cyc + 2 < exp_cyc) || (got_cyc > exp_cyc + 2)) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d +/-2", got_cyc, exp_cyc); end
    end
    checks++; if (err_seen != eb) begin errors++; $display("FAIL single_frame_err: got %0d pulses expected 0", err_seen - eb); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL single_hold: got %0h expected 55", rx_data); end
    last_good = 8'h55;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int ob;
    int unsigned eb;
    exp_q = '{8'hA5, 8'h00, 8'hFF};
    ob = obs_data.size();
    eb = err_seen;
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, BIT);
    wait_cyc(20);
    checks++; if (obs_data.size() - ob != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", obs_data.size() - ob, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (ob + i < obs_data.size()) begin
        checks++; if (obs_data[ob + i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data%0d: got %0h expected %0h", i, obs_data[ob + i], exp_q[i]); end
      end
    end
    checks++; if (err_seen != eb) begin errors++; $display("FAIL b2b_frame_err: got %0d pulses expected 0", err_seen - eb); end
    last_good = 8'hFF;
  endtask

  task automatic test_glitch();
    int ob;
    int unsigned eb;
    ob = obs_data.size();
    eb = err_seen;
    drive_bit(1'b0, 100);
    uart_rx = 1'b1;
    wait_cyc(BIT);
    checks++; if (obs_data.size() != ob) begin errors++; $display("FAIL glitch_valid: got %0d bytes expected 0", obs_data.size() - ob); end
    checks++; if (err_seen != eb) begin errors++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", err_seen - eb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_break();
    int ob;
    int unsigned eb;
    ob = obs_data.size();
    eb = err_seen;
    send_frame(8'h3C, 1'b0, BIT);
    uart_rx = 1'b0;
    drive_bit(1'b0, 10 * BIT);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %0b expected 1", busy); end
    drive_bit(1'b0, 10 * BIT);
    drive_bit(1'b1, BIT + 10);
    checks++; if (err_seen - eb != 1) begin errors++; $display("FAIL break_frame_err: got %0d pulses expected 1", err_seen - eb); end
    checks++; if (obs_data.size() != ob) begin errors++; $display("FAIL break_valid: got %0d bytes expected 0", obs_data.size() - ob); end
    checks++; if (rx_data !== last_good) begin errors++; $display("FAIL break_hold: got %0h expected %0h", rx_data, last_good); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_exit: got busy %0b expected 0", busy); end
    send_frame(8'h81, 1'b1, BIT);
    wait_cyc(20);
    checks++; if (obs_data.size() - ob != 1) begin errors++; $display("FAIL break_next_count: got %0d expected 1", obs_data.size() - ob); end
    if (obs_data.size() > ob) begin
      checks++; if (obs_data[ob] !== 8'h81) begin errors++; $display("FAIL break_next_data: got %0h expected 81", obs_data[ob]); end
    end
    last_good = 8'h81;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int ob;
    int unsigned eb;
    b = 8'h96;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BIT);
    drive_bit(b[4], HALF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %0b expected 1", busy); end
    rstn = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midreset_rx_data: got %0h expected 00", rx_data); end
    checks++; if ((rx_valid | frame_err | busy) !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got valid=%0b err=%0b busy=%0b expected all 0", rx_valid, frame_err, busy); end
    drive_bit(b[4], BIT - HALF);
    for (int i = 5; i < 8; i++) drive_bit(b[i], BIT);
    drive_bit(1'b1, BIT);
    rstn = 1'b1;
    last_good = 8'h00;
    ob = obs_data.size();
    eb = err_seen;
    wait_cyc(BIT);
    checks++; if ((obs_data.size() != ob) || (err_seen != eb)) begin errors++; $display("FAIL midreset_quiet: got %0d bytes %0d errs expected 0 0", obs_data.size() - ob, err_seen - eb); end
    send_frame(8'h12, 1'b1, BIT);
    wait_cyc(20);
    checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL midreset_next: got %0h expected 12", rx_data); end
    checks++; if (obs_data.size() - ob != 1) begin errors++; $display("FAIL midreset_next_count: got %0d expected 1", obs_data.size() - ob); end
    last_good = 8'h12;
  endtask

  task automatic test_baud_offset();
    int unsigned lens[2];
    int ob;
    lens[0] = (BIT * 100 + 51) / 103;
    lens[1] = (BIT * 100 + 48) / 97;
    for (int k = 0; k < 2; k++) begin
      ob = obs_data.size();
      send_frame(8'hC3, 1'b1, lens[k]);
      wait_cyc(20);
      checks++; if (obs_data.size() - ob != 1) begin errors++; $display("FAIL baud%0d_count: got %0d expected 1", k, obs_data.size() - ob); end
      if (obs_data.size() > ob) begin
        checks++; if (obs_data[ob] !== 8'hC3) begin errors++; $display("FAIL baud%0d_data: got %0h expected c3 (bit len %0d)", k, obs_data[ob], lens[k]); end
      end
    end
    last_good = 8'hC3;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int unsigned len;
    int ob;
    int unsigned eb;
    ob = obs_data.size();
    eb = err_seen;
    for (int i = 0; i < 2; i++) begin
      b   = 8'($urandom_range(0, 255));
      len = BIT - 10 + $urandom_range(0, 20);
      exp_q.push_back(b);
      send_frame(b, 1'b1, len);
    end
    wait_cyc(20);
    checks++; if (obs_data.size() - ob != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", obs_data.size() - ob, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (ob + i < obs_data.size()) begin
        checks++; if (obs_data[ob + i] !== exp_q[i]) begin errors++; $display("FAIL random_data%0d: got %0h expected %0h", i, obs_data[ob + i], exp_q[i]); end
      end
    end
    checks++; if (err_seen != eb) begin errors++; $display("FAIL random_frame_err: got %0d pulses expected 0", err_seen - eb); end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    checks++; if (rx_data !== last_good) begin errors++; $display("FAIL random_hold: got %0h expected %0h", rx_data, last_good); end
  endtask

  task automatic test_pulse_rules();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL pulse_overlap: got %0d cycles expected 0", both_cnt); end
    checks++; if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_cnt); end
    checks++; if (data_bad != 0) begin errors++; $display("FAIL data_without_valid: got %0d changes expected 0", data_bad); end
  endtask

  initial begin
    rstn    = 1'b0;
    uart_rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_baud_offset();
    test_random();
    test_pulse_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
